// File: rtl/stoch_signed_decimator.sv
// ============================================================================
// Module   : stoch_signed_decimator
// Purpose  : Multi-lane signed stochastic bitstream decoder. Each lane carries
//            a signed value as a positive-part stream (x_p) and a negative-
//            part stream (x_m). Over a window of N = 2^WINDOW_LOG2 valid
//            samples, each lane accumulates sum(x_p - x_m). The result is a
//            signed count in the range -N..+N. The value estimate is y/N.
//
// Optional : `define STOCH_DECIMATOR_CONTINUOUS_EN
//            Windows run back to back with no DONE state. out_valid becomes a
//            one-cycle pulse per window, and out_ready is ignored.
//            When the macro is undefined, the result is held in DONE until
//            out_ready is seen (backpressure).
//
// Ports    : CLK        in   rising-edge clock
//            RST        in   asynchronous active-high reset
//            start      in   begin (or restart) a decode window
//            in_valid   in   x_p/x_m carry a sample this cycle
//            x_p        in   [CHANNELS-1:0] positive-part bits, one per lane
//            x_m        in   [CHANNELS-1:0] negative-part bits, one per lane
//            out_ready  in   consumer accepts y
//            out_valid  out  y holds a completed window result
//            busy       out  window in progress or result pending
//            y          out  [CHANNELS-1:0][YW-1:0] signed counts, YW=WINDOW_LOG2+2
//
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stoch_signed_decimator #(
  parameter int CHANNELS    = 3,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   start,
  input  logic                                   in_valid,
  input  logic [CHANNELS-1:0]                    x_p,
  input  logic [CHANNELS-1:0]                    x_m,
  input  logic                                   out_ready,
  output logic                                   out_valid,
  output logic                                   busy,
  output logic [CHANNELS-1:0][WINDOW_LOG2+1:0]   y
);

  // A count of -N..+N needs WINDOW_LOG2+1 magnitude bits plus a sign bit.
  localparam int YW = WINDOW_LOG2 + 2;

  localparam logic [WINDOW_LOG2-1:0] c_cnt_last = {WINDOW_LOG2{1'b1}};
  localparam logic [WINDOW_LOG2-1:0] c_cnt_one  = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0]          c_acc_zero = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                       r_state;
  logic [WINDOW_LOG2-1:0]       r_cnt;
  logic [CHANNELS-1:0][YW-1:0]  r_acc;
  logic [CHANNELS-1:0][YW-1:0]  r_y;
  logic                         r_out_valid;

  logic [CHANNELS-1:0][YW-1:0]  w_acc_next;
  logic                         w_last;

  // Per-lane step is x_p - x_m, which is one of +1, 0 or -1. Both bits are
  // zero-extended to full width so that the subtraction wraps correctly in
  // two's complement. The magnitude never exceeds N, so no overflow occurs.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign w_acc_next[c] = r_acc[c]
                         + {{(YW-1){1'b0}}, x_p[c]}
                         - {{(YW-1){1'b0}}, x_m[c]};
  end

  // The valid sample taken while the counter reads N-1 closes the window.
  assign w_last = in_valid && (r_cnt == c_cnt_last);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
`ifdef STOCH_DECIMATOR_CONTINUOUS_EN
      // In continuous mode, out_valid is a single-cycle pulse.
      r_out_valid <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          // Samples arriving while idle are dropped.
          if (start) begin
            r_state <= S_ACCUM;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end

        S_ACCUM: begin
          if (start) begin
            // Restart the window. The sample on this cycle is discarded.
            r_cnt <= '0;
            r_acc <= '0;
          end else if (in_valid) begin
            // The counter wraps to zero on the last sample.
            r_cnt <= r_cnt + c_cnt_one;
            if (w_last) begin
              r_y         <= w_acc_next;
              r_out_valid <= 1'b1;
              for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= c_acc_zero;
              end
`ifndef STOCH_DECIMATOR_CONTINUOUS_EN
              r_state <= S_DONE;
`endif
            end else begin
              r_acc <= w_acc_next;
            end
          end
        end

        S_DONE: begin
          // Hold the result until the consumer takes it. Sample inputs are
          // ignored here.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (start) begin
              r_state <= S_ACCUM;
              r_cnt   <= '0;
              r_acc   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef STOCH_DECIMATOR_CONTINUOUS_EN
  // No backpressure path exists in continuous mode.
  logic w_unused_out_ready;
  assign w_unused_out_ready = out_ready;
`endif

  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);
  assign y         = r_y;

endmodule

`default_nettype wire
